// File: rtl/qam_pkg.sv
// Shared definitions for the QAM-16 transmit chain.
//   DATA_W_DEF     : default signed I/Q sample width
//   MAX_FACTOR_DEF : default largest upsampling ratio
//   state_e        : upsampler control state (IDLE / EMIT)
//   clamp_factor   : maps a requested ratio onto the supported range 1..max_f
package qam_pkg;

    localparam int unsigned DATA_W_DEF     = 4;
    localparam int unsigned MAX_FACTOR_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // 0 and 1 both mean pass-through; anything above max_f saturates.
    function automatic int unsigned clamp_factor(input int unsigned req,
                                                 input int unsigned max_f);
        if (req < 2) begin
            return 1;
        end else if (req > max_f) begin
            return max_f;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/upsample_phase_ctr.sv
// Phase counter for the I/Q upsampler.
// Holds the effective factor F of the current symbol and counts phases 0..F-1.
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   load_i        : start a new symbol (phase = 0, F = load_factor_i)
//   load_factor_i : clamped factor to latch on load (1..MAX_FACTOR)
//   advance_i     : current phase consumed downstream
//   last_o        : current phase is F-1
module upsample_phase_ctr #(
    parameter int unsigned FACTOR_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [FACTOR_W-1:0] load_factor_i,
    input  logic                advance_i,
    output logic                last_o
);

    logic [FACTOR_W-1:0] phase_q, phase_d;
    logic [FACTOR_W-1:0] f_q, f_d;

    assign last_o = (phase_q == f_q - FACTOR_W'(1));

    always_comb begin
        phase_d = phase_q;
        f_d     = f_q;
        if (load_i) begin
            // Load wins over advance: on a back-to-back edge the old last phase
            // is consumed and the new symbol starts at phase 0.
            phase_d = '0;
            f_d     = load_factor_i;
        end else if (advance_i) begin
            phase_d = last_o ? '0 : phase_q + FACTOR_W'(1);
        end
    end

    // F resets to 1 so last_o is well defined while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
            f_q     <= FACTOR_W'(1);
        end else begin
            phase_q <= phase_d;
            f_q     <= f_d;
        end
    end

endmodule

// File: rtl/iq_upsampler_stream.sv
// I/Q upsampler with valid/ready handshakes on both sides.
// Each accepted symbol is emitted as F output beats, either zero-stuffed
// (symbol on phase 0, zeros after) or sample-and-hold (symbol on every phase).
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   factor, hold_mode     : ratio and mode, sampled only on symbol accept
//   in_valid/in_ready     : input handshake; iin/qin signed symbol
//   out_valid/out_ready   : output handshake; iup/qup signed samples
//   sym_start             : high on phase 0 of each symbol
//   underflow             : one-cycle pulse when a symbol ends with no successor
module iq_upsampler_stream
    import qam_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_FACTOR = MAX_FACTOR_DEF,
    parameter int unsigned FACTOR_W   = $clog2(MAX_FACTOR + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FACTOR_W-1:0] factor,
    input  logic                hold_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   iin,
    input  logic [DATA_W-1:0]   qin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   iup,
    output logic [DATA_W-1:0]   qup,
    output logic                sym_start,
    output logic                underflow
);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   isym_q, isym_d;
    logic [DATA_W-1:0]   qsym_q, qsym_d;
    logic [DATA_W-1:0]   iup_q, iup_d;
    logic [DATA_W-1:0]   qup_q, qup_d;
    logic                sym_start_q, sym_start_d;
    logic                underflow_q, underflow_d;

    logic                last;
    logic                accept;
    logic                advance;
    logic [FACTOR_W-1:0] factor_eff;

    assign factor_eff = FACTOR_W'(clamp_factor(32'(factor), MAX_FACTOR));

    assign out_valid = (state_q == EMIT);
    // Combinational from out_ready so the next symbol can be taken on the same
    // edge that consumes the last phase of the current one.
    assign in_ready  = !reset && ((state_q == IDLE) || (last && out_ready));
    assign accept    = in_valid && in_ready;
    assign advance   = out_valid && out_ready;

    assign iup       = iup_q;
    assign qup       = qup_q;
    assign sym_start = sym_start_q;
    assign underflow = underflow_q;

    upsample_phase_ctr #(
        .FACTOR_W (FACTOR_W)
    ) u_phase_ctr (
        .clk_i         (clk),
        .rst_i         (reset),
        .load_i        (accept),
        .load_factor_i (factor_eff),
        .advance_i     (advance),
        .last_o        (last)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        isym_d      = isym_q;
        qsym_d      = qsym_q;
        iup_d       = iup_q;
        qup_d       = qup_q;
        sym_start_d = sym_start_q;
        underflow_d = 1'b0;

        if (accept) begin
            state_d     = EMIT;
            mode_d      = hold_mode;
            isym_d      = iin;
            qsym_d      = qin;
            iup_d       = iin;
            qup_d       = qin;
            sym_start_d = 1'b1;
        end else if (advance && last) begin
            state_d     = IDLE;
            iup_d       = '0;
            qup_d       = '0;
            sym_start_d = 1'b0;
            underflow_d = 1'b1;
        end else if (advance) begin
            iup_d       = mode_q ? isym_q : '0;
            qup_d       = mode_q ? qsym_q : '0;
            sym_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            isym_q      <= '0;
            qsym_q      <= '0;
            iup_q       <= '0;
            qup_q       <= '0;
            sym_start_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            isym_q      <= isym_d;
            qsym_q      <= qsym_d;
            iup_q       <= iup_d;
            qup_q       <= qup_d;
            sym_start_q <= sym_start_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_iq_upsampler_stream.sv
// Directed bench for iq_upsampler_stream (DATA_W=4, MAX_FACTOR=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_iq_upsampler_stream;

    localparam int unsigned DATA_W     = 4;
    localparam int unsigned MAX_FACTOR = 16;
    localparam int unsigned FACTOR_W   = 5;

    logic                       clk;
    logic                       reset;
    logic [FACTOR_W-1:0]        factor;
    logic                       hold_mode;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [DATA_W-1:0]   iin;
    logic signed [DATA_W-1:0]   qin;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          iup;
    logic [DATA_W-1:0]          qup;
    logic                       sym_start;
    logic                       underflow;

    int checks;
    int errors;

    iq_upsampler_stream #(
        .DATA_W     (DATA_W),
        .MAX_FACTOR (MAX_FACTOR),
        .FACTOR_W   (FACTOR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .factor    (factor),
        .hold_mode (hold_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .iin       (iin),
        .qin       (qin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iup       (iup),
        .qup       (qup),
        .sym_start (sym_start),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; factor = 5'd4; hold_mode = 1'b0; in_valid = 1'b0;
        iin = '0; qin = '0; out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || iup !== 4'd0 || qup !== 4'd0 || sym_start !== 1'b0
            || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%0d q=%0d ss=%b uf=%b required all 0",
                     out_valid, iup, qup, sym_start, underflow);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%b v=%b required rdy=1 v=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_zero_stuff();
        logic signed [3:0] ei [8];
        logic signed [3:0] eq [8];
        ei = '{4'sd3, 4'sd0, 4'sd0, 4'sd0, -4'sd5, 4'sd0, 4'sd0, 4'sd0};
        eq = '{-4'sd2, 4'sd0, 4'sd0, 4'sd0, 4'sd7, 4'sd0, 4'sd0, 4'sd0};
        factor = 5'd4; hold_mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; iin = 4'sd3; qin = -4'sd2;
        step();
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (out_valid !== 1'b1 || iup !== ei[b] || qup !== eq[b]
                || sym_start !== (b % 4 == 0) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL zs_beat%0d: got v=%b i=%0d q=%0d ss=%b uf=%b required v=1 i=%0d q=%0d ss=%b uf=0",
                         b, out_valid, $signed(iup), $signed(qup), sym_start, underflow,
                         ei[b], eq[b], (b % 4 == 0));
            end
            checks++;
            if (in_ready !== (b % 4 == 3)) begin
                errors++;
                $display("FAIL zs_ready%0d: got %b required %b", b, in_ready, (b % 4 == 3));
            end
            if (b == 0) begin iin = -4'sd5; qin = 4'sd7; end
            if (b == 4) in_valid = 1'b0;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b1 || iup !== 4'd0 || qup !== 4'd0) begin
            errors++;
            $display("FAIL zs_end: got v=%b uf=%b i=%0d q=%0d required v=0 uf=1 i=0 q=0",
                     out_valid, underflow, iup, qup);
        end
        step();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL zs_uf_pulse: got %b required 0", underflow);
        end
    endtask

    task automatic test_hold();
        factor = 5'd3; hold_mode = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; iin = -4'sd8; qin = 4'sd7;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (out_valid !== 1'b1 || iup !== 4'b1000 || qup !== 4'b0111
                || sym_start !== (b == 0) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL hold_beat%0d: got v=%b i=%0d q=%0d ss=%b required v=1 i=-8 q=7 ss=%b",
                         b, out_valid, $signed(iup), $signed(qup), sym_start, (b == 0));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b1 || iup !== 4'd0) begin
            errors++;
            $display("FAIL hold_end: got v=%b uf=%b i=%0d required v=0 uf=1 i=0",
                     out_valid, underflow, iup);
        end
        step();
        checks++;
        if (underflow !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_uf_once: got uf=%b v=%b required 0 0", underflow, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int beats;
        beats = 0;
        factor = 5'd4; hold_mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; iin = 4'sd6; qin = -4'sd3;
        step();
        in_valid = 1'b0;
        checks++;
        if (iup !== 4'd6 || qup !== 4'b1101 || sym_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_phase0: got i=%0d q=%0d ss=%b rdy=%b required i=6 q=-3 ss=1 rdy=0",
                     $signed(iup), $signed(qup), sym_start, in_ready);
        end
        if (out_valid && out_ready) beats++;
        step();
        if (out_valid && out_ready) beats++;
        step();
        // Phase 2 now on the outputs; stall it.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || iup !== 4'd0 || qup !== 4'd0 || sym_start !== 1'b0
                || in_ready !== 1'b0 || underflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got v=%b i=%0d q=%0d ss=%b rdy=%b uf=%b required v=1 zeros rdy=0",
                         c, out_valid, iup, qup, sym_start, in_ready, underflow);
            end
            if (out_valid && out_ready) beats++;
            step();
        end
        out_ready = 1'b1;
        if (out_valid && out_ready) beats++;
        step();
        // Phase 3: in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_last_stalled: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_last_ready: got %b required 1", in_ready);
        end
        if (out_valid && out_ready) beats++;
        step();
        checks++;
        if (beats !== 4 || out_valid !== 1'b0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_total: got beats=%0d v=%b uf=%b required beats=4 v=0 uf=1",
                     beats, out_valid, underflow);
        end
        step();
    endtask

    task automatic test_factor_edges();
        int beats;
        int starts;
        for (int fv = 0; fv < 2; fv++) begin
            factor = 5'(fv); hold_mode = 1'b0; out_ready = 1'b1;
            in_valid = 1'b1; iin = 4'sd1; qin = -4'sd1;
            step();
            for (int k = 1; k <= 3; k++) begin
                checks++;
                if (out_valid !== 1'b1 || $signed(iup) !== k || $signed(qup) !== -k
                    || sym_start !== 1'b1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL f%0d_sym%0d: got v=%b i=%0d q=%0d ss=%b rdy=%b required v=1 i=%0d q=%0d ss=1 rdy=1",
                             fv, k, out_valid, $signed(iup), $signed(qup), sym_start, in_ready, k, -k);
                end
                if (k < 3) begin
                    iin = 4'(k + 1); qin = 4'(-(k + 1));
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
            checks++;
            if (out_valid !== 1'b0 || underflow !== 1'b1) begin
                errors++;
                $display("FAIL f%0d_end: got v=%b uf=%b required v=0 uf=1", fv, out_valid, underflow);
            end
            step();
        end

        factor = 5'd31; hold_mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; iin = 4'sd5; qin = 4'sd5;
        step();
        in_valid = 1'b0;
        beats = 0;
        starts = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            beats++;
            if (sym_start) starts++;
            step();
        end
        checks++;
        if (beats !== 16 || starts !== 1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL f31_clamp: got beats=%0d starts=%0d v=%b required beats=16 starts=1 v=0",
                     beats, starts, out_valid);
        end
        step();
    endtask

    task automatic test_mid_change();
        logic signed [3:0] ei [6];
        logic signed [3:0] eq [6];
        ei = '{4'sd2, 4'sd0, 4'sd0, 4'sd0, -4'sd3, -4'sd3};
        eq = '{-4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd4, 4'sd4};
        factor = 5'd4; hold_mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; iin = 4'sd2; qin = -4'sd1;
        step();
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (out_valid !== 1'b1 || iup !== ei[b] || qup !== eq[b]
                || sym_start !== (b == 0 || b == 4)) begin
                errors++;
                $display("FAIL mid_beat%0d: got v=%b i=%0d q=%0d ss=%b required v=1 i=%0d q=%0d ss=%b",
                         b, out_valid, $signed(iup), $signed(qup), sym_start, ei[b], eq[b],
                         (b == 0 || b == 4));
            end
            if (b == 0) begin iin = -4'sd3; qin = 4'sd4; end
            if (b == 1) begin factor = 5'd2; hold_mode = 1'b1; end
            if (b == 4) in_valid = 1'b0;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_end: got v=%b uf=%b required v=0 uf=1", out_valid, underflow);
        end
        step();
    endtask

    task automatic test_reset_mid();
        factor = 5'd4; hold_mode = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; iin = 4'sd7; qin = 4'sd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        // Phase 2 visible; assert reset between edges.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || iup !== 4'd0 || qup !== 4'd0 || in_ready !== 1'b0
            || sym_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b i=%0d q=%0d rdy=%b ss=%b required all 0",
                     out_valid, iup, qup, in_ready, sym_start);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || underflow !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_leftover%0d: got v=%b uf=%b required 0 0", c, out_valid, underflow);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_stuff();
        test_hold();
        test_backpressure();
        test_factor_edges();
        test_mid_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
